// File: rtl/seq_alu_if.sv
// ---------------------------------------------------------------------------
// seq_alu_if -- operand/result handshake bundle for seq_alu.
//
// Parameters:
//   WIDTH      operand/result width
// Signals:
//   in_valid   issuer presents x/y/sel
//   in_ready   ALU can accept (IDLE only)
//   x, y       operands
//   sel        4-bit operation select
//   out_valid  result registers hold a finished result
//   out_ready  consumer takes the result
//   result     primary result
//   result2    high product / remainder, else 0
//   of, cf     signed overflow / carry-out (add, sub only)
//   dz         divide by zero
//   equal      x == y of the accepted operands
// Modports: master = issuer/consumer side, slave = ALU side.
// ---------------------------------------------------------------------------
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result2;
  logic             of;
  logic             cf;
  logic             dz;
  logic             equal;

  modport master (
    output in_valid, x, y, sel, out_ready,
    input  in_ready, out_valid, result, result2, of, cf, dz, equal
  );

  modport slave (
    input  in_valid, x, y, sel, out_ready,
    output in_ready, out_valid, result, result2, of, cf, dz, equal
  );
endinterface

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- multi-cycle WIDTH-bit ALU with registered results.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_alu_if.slave: valid/ready operand input, valid/ready result
//
// sel: 0 shl, 1 sra, 2 srl, 3 mul (lo/hi), 4 div (quot/rem), 5 add, 6 sub,
//      7 and, 8 or, 9 xor, 10 nor, 11 slt, 12 sltu, 13-15 all outputs 0.
//
// Build option SEQ_ALU_ITER_EN: when defined, mul/div with a non-zero y run
// on a shared iterative shift-add / restoring-divide engine (WIDTH cycles in
// BUSY). When undefined, mul/div are computed combinationally at acceptance.
// Divide by zero always completes in one cycle.
// ---------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_alu_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, res2_q, res2_d;
  logic             of_q, of_d, cf_q, cf_d, dz_q, dz_d, eq_q, eq_d;

  // Single-cycle function of the live inputs, used at acceptance.
  logic [WIDTH-1:0] f_res, f_res2;
  logic             f_of, f_cf, f_dz, f_eq;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] y_eff;
  logic [SHW-1:0]   amt;
  logic             is_sub;
`ifndef SEQ_ALU_ITER_EN
  logic [2*WIDTH-1:0] prod;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    f_res  = '0;
    f_res2 = '0;
    f_of   = 1'b0;
    f_cf   = 1'b0;
    f_dz   = 1'b0;
    f_eq   = (bus.sel <= 4'd12) && (bus.x == bus.y);
    amt    = bus.y[SHW-1:0];
    is_sub = (bus.sel == 4'd6);
    // Subtract is x + ~y + 1 on the same adder.
    y_eff  = is_sub ? ~bus.y : bus.y;
    sum    = {1'b0, bus.x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, is_sub};
`ifndef SEQ_ALU_ITER_EN
    prod   = {{WIDTH{1'b0}}, bus.x} * {{WIDTH{1'b0}}, bus.y};
`endif
    case (bus.sel)
      4'd0:  f_res = bus.x << amt;
      4'd1:  f_res = $unsigned($signed(bus.x) >>> amt);
      4'd2:  f_res = bus.x >> amt;
`ifndef SEQ_ALU_ITER_EN
      4'd3:  {f_res2, f_res} = prod;
`endif
      4'd4: begin
        if (bus.y == '0) begin
          f_res  = '1;
          f_res2 = bus.x;
          f_dz   = 1'b1;
        end
`ifndef SEQ_ALU_ITER_EN
        else begin
          f_res  = bus.x / bus.y;
          f_res2 = bus.x % bus.y;
        end
`endif
      end
      4'd5, 4'd6: begin
        f_res = sum[WIDTH-1:0];
        f_cf  = sum[WIDTH];
        // Carry into the MSB recovered from the MSB sum bit.
        f_of  = (bus.x[WIDTH-1] ^ y_eff[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
      end
      4'd7:  f_res = bus.x & bus.y;
      4'd8:  f_res = bus.x | bus.y;
      4'd9:  f_res = bus.x ^ bus.y;
      4'd10: f_res = ~(bus.x | bus.y);
      4'd11: f_res = {{(WIDTH-1){1'b0}}, $signed(bus.x) < $signed(bus.y)};
      4'd12: f_res = {{(WIDTH-1){1'b0}}, bus.x < bus.y};
      default: ;
    endcase
  end

`ifdef SEQ_ALU_ITER_EN
  // Shared engine: {hi,lo} is the product/shift register for mul, and
  // {remainder, dividend->quotient} for div. op holds x (mul) or y (div).
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, op_q, op_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [WIDTH:0]   m_sum, r_shift;
  logic             go_iter;

  always_comb begin
    go_iter = ((bus.sel == 4'd3) || (bus.sel == 4'd4)) && (bus.y != '0);
    m_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
    r_shift = {hi_q, lo_q[WIDTH-1]};
    if (div_q) begin
      if (r_shift >= {1'b0, op_q}) begin
        hi_step = r_shift[WIDTH-1:0] - op_q;
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = r_shift[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_step, lo_step} = {m_sum, lo_q[WIDTH-1:1]};
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    res2_d  = res2_q;
    of_d    = of_q;
    cf_d    = cf_q;
    dz_d    = dz_q;
    eq_d    = eq_q;
`ifdef SEQ_ALU_ITER_EN
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          eq_d = f_eq;
`ifdef SEQ_ALU_ITER_EN
          if (go_iter) begin
            state_d = S_BUSY;
            div_d   = (bus.sel == 4'd4);
            op_d    = (bus.sel == 4'd4) ? bus.y : bus.x;
            lo_d    = (bus.sel == 4'd4) ? bus.x : bus.y;
            hi_d    = '0;
            cnt_d   = '0;
            of_d    = 1'b0;
            cf_d    = 1'b0;
            dz_d    = 1'b0;
          end else
`endif
          begin
            state_d = S_DONE;
            res_d   = f_res;
            res2_d  = f_res2;
            of_d    = f_of;
            cf_d    = f_cf;
            dz_d    = f_dz;
          end
        end
      end
`ifdef SEQ_ALU_ITER_EN
      S_BUSY: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = S_DONE;
          res_d   = lo_step;
          res2_d  = hi_step;
        end
      end
`endif
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      res2_q  <= '0;
      of_q    <= 1'b0;
      cf_q    <= 1'b0;
      dz_q    <= 1'b0;
      eq_q    <= 1'b0;
`ifdef SEQ_ALU_ITER_EN
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      res2_q  <= res2_d;
      of_q    <= of_d;
      cf_q    <= cf_d;
      dz_q    <= dz_d;
      eq_q    <= eq_d;
`ifdef SEQ_ALU_ITER_EN
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = res_q;
  assign bus.result2   = res2_q;
  assign bus.of        = of_q;
  assign bus.cf        = cf_q;
  assign bus.dz        = dz_q;
  assign bus.equal     = eq_q;
endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu -- directed, table-driven bench for seq_alu (WIDTH=32), plus
// hand-written sequences for backpressure and reset during an operation.
// Latency is counted in clock edges from the accepting edge to the first
// edge that sees out_valid high.
// ---------------------------------------------------------------------------
module tb_seq_alu;
  localparam int W = 32;
`ifdef SEQ_ALU_ITER_EN
  localparam int LAT_MD = W + 1;
`else
  localparam int LAT_MD = 1;
`endif
  localparam int TIMEOUT = 200;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string          name;
    logic [W-1:0]   x, y;
    logic [3:0]     sel;
    logic [W-1:0]   res, res2;
    logic           of, cf, dz, eq;
    int             lat;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input string n, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [3:0] sel, input logic [W-1:0] res,
                                  input logic [W-1:0] res2, input logic of, input logic cf,
                                  input logic dz, input logic eq, input int lat);
    vec_t v;
    v.name = n; v.x = x; v.y = y; v.sel = sel; v.res = res; v.res2 = res2;
    v.of = of; v.cf = cf; v.dz = dz; v.eq = eq; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Present an op at a negedge once in_ready is seen; returns #1 after the
  // accepting edge with in_valid dropped.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] sel);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    bus.x = x; bus.y = y; bus.sel = sel; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Called at a negedge with out_valid high.
  task automatic handoff(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check({name, ".in_ready_after"}, bus.in_ready, 1'b1);
    check({name, ".out_valid_after"}, bus.out_valid, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    issue(v.x, v.y, v.sel);
    wait_done(lat);
    check({v.name, ".latency"}, lat, v.lat);
    check({v.name, ".result"}, bus.result, v.res);
    check({v.name, ".result2"}, bus.result2, v.res2);
    check({v.name, ".flags(of,cf,dz,eq)"}, {bus.of, bus.cf, bus.dz, bus.equal},
          {v.of, v.cf, v.dz, v.eq});
    handoff(v.name);
  endtask

  task automatic check_reset_state(input string name);
    check({name, ".in_ready"}, bus.in_ready, 1'b1);
    check({name, ".out_valid"}, bus.out_valid, 1'b0);
    check({name, ".result"}, bus.result, '0);
    check({name, ".result2"}, bus.result2, '0);
    check({name, ".flags(of,cf,dz,eq)"}, {bus.of, bus.cf, bus.dz, bus.equal}, 4'b0000);
  endtask

  initial begin
    int lat;
    //       name        x             y             sel    result        result2       of cf dz eq lat
    add_vec("add_ovf",   32'h7FFFFFFF, 32'h00000001, 4'd5,  32'h80000000, 32'h0,        1, 0, 0, 0, 1);
    add_vec("sub_borrow",32'h00000003, 32'h00000005, 4'd6,  32'hFFFFFFFE, 32'h0,        0, 0, 0, 0, 1);
    add_vec("sub_nobor", 32'h00000005, 32'h00000003, 4'd6,  32'h00000002, 32'h0,        0, 1, 0, 0, 1);
    add_vec("add_carry", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5,  32'hFFFFFFFE, 32'h0,        0, 1, 0, 1, 1);
    add_vec("sub_ovf",   32'h80000000, 32'h00000001, 4'd6,  32'h7FFFFFFF, 32'h0,        1, 1, 0, 0, 1);
    add_vec("mul_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3,  32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 1, LAT_MD);
    add_vec("mul_shift", 32'h12345678, 32'h00000010, 4'd3,  32'h23456780, 32'h00000001, 0, 0, 0, 0, LAT_MD);
    add_vec("mul_by0",   32'h00000003, 32'h00000000, 4'd3,  32'h0,        32'h0,        0, 0, 0, 0, 1);
    add_vec("div_100_7", 32'd100,      32'd7,        4'd4,  32'd14,       32'd2,        0, 0, 0, 0, LAT_MD);
    add_vec("div_big",   32'hFFFFFFFF, 32'h00000010, 4'd4,  32'h0FFFFFFF, 32'h0000000F, 0, 0, 0, 0, LAT_MD);
    add_vec("div_zero",  32'd5,        32'd0,        4'd4,  32'hFFFFFFFF, 32'd5,        0, 0, 1, 0, 1);
    add_vec("shl",       32'h00000001, 32'h00000023, 4'd0,  32'h00000008, 32'h0,        0, 0, 0, 0, 1);
    add_vec("sra",       32'h80000000, 32'h00000004, 4'd1,  32'hF8000000, 32'h0,        0, 0, 0, 0, 1);
    add_vec("srl",       32'h80000000, 32'h00000004, 4'd2,  32'h08000000, 32'h0,        0, 0, 0, 0, 1);
    add_vec("and",       32'hF0F01234, 32'h0FF0FFFF, 4'd7,  32'h00F01234, 32'h0,        0, 0, 0, 0, 1);
    add_vec("and_eq",    32'hA5A5A5A5, 32'hA5A5A5A5, 4'd7,  32'hA5A5A5A5, 32'h0,        0, 0, 0, 1, 1);
    add_vec("or",        32'hF0000000, 32'h0000000F, 4'd8,  32'hF000000F, 32'h0,        0, 0, 0, 0, 1);
    add_vec("xor",       32'hFFFF0000, 32'h0F0F0F0F, 4'd9,  32'hF0F00F0F, 32'h0,        0, 0, 0, 0, 1);
    add_vec("nor",       32'hF0000000, 32'h0000000F, 4'd10, 32'h0FFFFFF0, 32'h0,        0, 0, 0, 0, 1);
    add_vec("slt",       32'hFFFFFFFF, 32'h00000001, 4'd11, 32'h00000001, 32'h0,        0, 0, 0, 0, 1);
    add_vec("sltu_no",   32'hFFFFFFFF, 32'h00000001, 4'd12, 32'h00000000, 32'h0,        0, 0, 0, 0, 1);
    add_vec("sltu_yes",  32'h00000001, 32'hFFFFFFFF, 4'd12, 32'h00000001, 32'h0,        0, 0, 0, 0, 1);
    add_vec("sel13",     32'h00000005, 32'h00000005, 4'd13, 32'h0,        32'h0,        0, 0, 0, 0, 1);

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x = '0; bus.y = '0; bus.sel = '0;
    rst_n = 1'b0;
    #1 check_reset_state("reset");
    #20;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) check_reset_state("post_reset");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result held, no acceptance until handoff.
    issue(32'h00FF0000, 32'h000000FF, 4'd8);
    bus.in_valid = 1'b1; bus.x = 32'h11111111; bus.y = 32'h22222222; bus.sel = 4'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp.result_c%0d", i), bus.result, 32'h00FF00FF);
      check($sformatf("bp.valid_ready_c%0d", i), {bus.out_valid, bus.in_ready}, 2'b10);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("bp.in_ready_after_handoff", bus.in_ready, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_done(lat);
    check("bp.second_latency", lat, 1);
    check("bp.second_result", bus.result, 32'h33333333);
    handoff("bp2");

    // Reset while the multiply is in flight (iteration 10 in the iterative
    // build, held in DONE otherwise).
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3);
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1 check_reset_state("mid_mul_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        checks++;
        errors++;
        $display("FAIL mid_mul_reset.no_out_valid: got 1 expected 0 at cycle %0d", i);
        break;
      end
    end
    issue(32'd1, 32'd2, 4'd12);
    wait_done(lat);
    check("after_reset_sltu.latency", lat, 1);
    check("after_reset_sltu.result", bus.result, 32'd1);
    handoff("after_reset_sltu");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
